seq_divider_8bit: RTL and testbench

//  Multi-cycle unsigned 8-bit restoring divider: quotient/remainder = dividend / divisor.

---
 rtl/seq_divider_8bit_pkg.sv | 15 +
 rtl/cla_subtractor_8bit.sv | 35 +++
 rtl/seq_divider_8bit.sv | 134 +++++++++++++
 tb/tb_seq_divider_8bit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_8bit_pkg.sv
// Shared constants and state encoding for the sequential 8-bit restoring divider.
package seq_divider_8bit_pkg;

    localparam int DIV_W    = 8;
    localparam int DIV_ITER = 8;

    localparam logic [2:0] CNT_INIT = 3'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/cla_subtractor_8bit.sv
// 8-bit subtractor built on the carry-lookahead adder: diff = a + ~b + 1.
// cout=1 means a >= b (no borrow).
module cla_subtractor_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff,
    output logic       cout
);

    logic [7:0] b_inv_s;
    logic [7:0] g_s;
    logic [7:0] p_s;
    logic [8:0] c_s;

    assign b_inv_s = ~b;
    assign g_s     = a & b_inv_s;
    assign p_s     = a ^ b_inv_s;
    assign c_s[0]  = 1'b1;

    // Two 4-bit lookahead groups; the upper group takes the lower group's carry-out.
    for (genvar j = 0; j < 2; j++) begin : g_grp
        localparam int B = 4 * j;
        assign c_s[B+1] = g_s[B] | (p_s[B] & c_s[B]);
        assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & c_s[B]);
        assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                        | (p_s[B+2] & p_s[B+1] & p_s[B] & c_s[B]);
        assign c_s[B+4] = g_s[B+3] | (p_s[B+3] & g_s[B+2]) | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                        | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B])
                        | (p_s[B+3] & p_s[B+2] & p_s[B+1] & p_s[B] & c_s[B]);
    end

    assign diff = p_s ^ c_s[7:0];
    assign cout = c_s[8];

endmodule

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned 8-bit restoring divider with start/busy/done handshake.
// One quotient bit per cycle; the 9th partial-remainder bit exists only transiently in the shift.
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] q_q, q_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rout_q, rout_d;
    logic             dbz_q, dbz_d;

    logic [DIV_W:0]   sh_s;
    logic [DIV_W-1:0] diff_s;
    logic             cout_s;
    logic             accept_s;
    logic [DIV_W-1:0] rem_next_s;
    logic [DIV_W-1:0] q_next_s;

    assign sh_s = {rem_q, q_q[DIV_W-1]};

    cla_subtractor_8bit u_sub (
        .a    (sh_s[DIV_W-1:0]),
        .b    (dvs_q),
        .diff (diff_s),
        .cout (cout_s)
    );

    // When the shifted-out bit is set, sh >= 256 > divisor, so the subtraction always fits.
    assign accept_s   = sh_s[DIV_W] | cout_s;
    assign rem_next_s = accept_s ? diff_s : sh_s[DIV_W-1:0];
    assign q_next_s   = {q_q[DIV_W-2:0], accept_s};

    // Next-state and registered-output logic for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && (divisor != 8'd0)) begin
                    dvs_d   = divisor;
                    rem_d   = 8'd0;
                    q_d     = dividend;
                    cnt_d   = CNT_INIT;
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                end else if (start) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quot_d  = 8'hFF;
                    rout_d  = dividend;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = rem_next_s;
                q_d   = q_next_s;
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quot_d  = q_next_s;
                    rout_d  = rem_next_s;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rem_q   <= 8'd0;
            q_q     <= 8'd0;
            dvs_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= 8'd0;
            rout_q  <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rout_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed cases plus a random sweep,
// expected results queued at issue time and compared when done pulses.
module tb_seq_divider_8bit;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    seq_divider_8bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Drive start for one posedge; returns at the negedge of cycle E0+1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts cycles since the start edge, busy_n counts busy cycles.
    task automatic wait_done(input int lat0, output int lat, output int busy_n);
        lat = lat0; busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++; failures++;
            $error("FAIL timeout observed=no_done expected=done");
        end
    endtask

    task automatic compare_result(input string tag, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},   {8'd0, quotient},  {8'd0, e.q});
            check({tag, "_r"},   {8'd0, remainder}, {8'd0, e.r});
            check({tag, "_dbz"}, {15'd0, div_by_zero}, {15'd0, e.dbz});
            if (b != 8'd0) begin
                check({tag, "_inv"}, 16'(quotient) * 16'(b) + 16'(remainder), {8'd0, a});
                check({tag, "_rlt"}, {15'd0, remainder < b}, 16'd1);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int lat, bn;
        push_exp(a, b);
        issue(a, b);
        wait_done(1, lat, bn);
        check({tag, "_lat"},  16'(lat), (b == 8'd0) ? 16'd1 : 16'd9);
        check({tag, "_busy"}, 16'(bn),  (b == 8'd0) ? 16'd0 : 16'd8);
        compare_result(tag, a, b);
        @(negedge clk);
        check({tag, "_pulse"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        int lat, bn;
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_q",    {8'd0, quotient}, 16'd0);
        check("rst_r",    {8'd0, remainder}, 16'd0);
        check("rst_dbz",  {15'd0, div_by_zero}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("t1_100_7", 8'd100, 8'd7);
        run_op("t2_255_1", 8'd255, 8'd1);
        run_op("t2_0_3",   8'd0,   8'd3);
        run_op("t2_200_255", 8'd200, 8'd255);
        run_op("t2_255_128", 8'd255, 8'd128);
        run_op("t3_5_0",   8'd5,   8'd0);

        // Start during CALC is ignored and operands may change freely.
        push_exp(8'd100, 8'd7);
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat, bn);
        check("t4_lat", 16'(lat), 16'd9);
        compare_result("t4", 8'd100, 8'd7);
        @(negedge clk);

        // Reset mid-CALC abandons the operation.
        issue(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", {15'd0, busy}, 16'd0);
        check("t5_q",    {8'd0, quotient}, 16'd0);
        check("t5_r",    {8'd0, remainder}, 16'd0);
        bn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) bn++;
            @(negedge clk);
        end
        check("t5_nodone", 16'(bn), 16'd0);
        run_op("t5_9_3", 8'd9, 8'd3);

        // Start held high: back-to-back acceptance in the DONE cycle.
        push_exp(8'd50, 8'd6);
        start = 1'b1; dividend = 8'd50; divisor = 8'd6;
        @(negedge clk);
        wait_done(1, lat, bn);
        check("t6a_lat", 16'(lat), 16'd9);
        compare_result("t6a", 8'd50, 8'd6);
        push_exp(8'd81, 8'd9);
        dividend = 8'd81; divisor = 8'd9;
        @(negedge clk);
        wait_done(1, lat, bn);
        start = 1'b0;
        check("t6_period", 16'(lat), 16'd9);
        compare_result("t6b", 8'd81, 8'd9);
        @(negedge clk);
        check("t6_pulse", {15'd0, done}, 16'd0);

        // Random sweep, with occasional zero divisors.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = (i % 37 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op("rnd", a, b);
        end

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
